// File: rtl/avalon_mm_pwm_fade_sequencer.sv
// avalon_mm_pwm_fade_sequencer
//
// Purpose: autonomous duty-cycle fader for a 4-channel Avalon-MM PWM block.
// The CPU programs a per-channel target duty, a shared step and a shared tick
// interval through the slave port. On every tick each channel's current duty
// moves one step toward its target without overshoot or wrap. Every changed
// value is pushed into the PWM comparison register (PWM_CMP_BASE + channel)
// through the master port, with channels served round-robin.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   s_address/s_read/s_readdata/s_write/s_writedata
//                     Avalon-MM slave, no waitrequest, read data registered
//                     (valid the cycle after s_read)
//   m_address/m_write/m_writedata/m_waitrequest
//                     Avalon-MM master (write only) into the PWM register map
//   irq               ramp-complete interrupt, level, active-high
//
// Slave map: 0-3 TARGET1-4, 4 STEP, 5 INTERVAL, 6 CTRL (b0 enable, b1 irq_en,
//   b2 write-1 clears irq_pending), 7 STATUS (b3:0 busy, b4 irq_pending),
//   8-11 CUR1-4.
//
// Build option: define PWM_FADE_IRQ_EN to include the completion interrupt
// (irq_pending, CTRL b1/b2, STATUS b4). Without it irq is tied low and those
// bits read 0.
module avalon_mm_pwm_fade_sequencer #(
    parameter int DUTY_W       = 16,
    parameter int TICK_W       = 16,
    parameter int PWM_CMP_BASE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        s_address,
    input  logic              s_read,
    output logic [15:0]       s_readdata,
    input  logic              s_write,
    input  logic [15:0]       s_writedata,
    output logic [3:0]        m_address,
    output logic              m_write,
    output logic [DUTY_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    output logic              irq
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    logic [DUTY_W-1:0] r_target [4];
    logic [DUTY_W-1:0] r_cur    [4];
    logic [DUTY_W-1:0] r_step;
    logic [TICK_W-1:0] r_interval;
    logic              r_enable;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [3:0]        r_dirty;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        r_ch;
    logic [3:0]        r_m_address;
    logic              r_m_write;
    logic [DUTY_W-1:0] r_m_writedata;
    logic [15:0]       r_readdata;
    state_t            r_state;

    state_t            w_state_next;
    logic              w_tick;
    logic              w_launch;
    logic              w_accept;
    logic              w_sel_valid;
    logic [1:0]        w_sel_ch;
    logic [DUTY_W-1:0] w_cur_next [4];
    logic [3:0]        w_changed;
    logic [3:0]        w_busy;
    logic [3:0]        w_dirty_next;
    logic [15:0]       w_rdata;
    logic              w_irq_pending;
    logic              w_irq_en;

    // One ramp step toward tgt. The extra MSB keeps the sum/difference from
    // wrapping, so large steps clamp to the target instead of overshooting.
    function automatic logic [DUTY_W-1:0] ramp_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0]   sum;
        logic [DUTY_W:0]   dif;
        logic [DUTY_W-1:0] res;
        sum = {1'b0, cur} + {1'b0, step};
        dif = {1'b0, cur} - {1'b0, step};
        res = cur;
        if (cur < tgt) begin
            if (sum >= {1'b0, tgt}) res = tgt;
            else                    res = sum[DUTY_W-1:0];
        end else if (cur > tgt) begin
            if (dif[DUTY_W] || (dif[DUTY_W-1:0] <= tgt)) res = tgt;
            else                                         res = dif[DUTY_W-1:0];
        end
        return res;
    endfunction

    // ---------------- tick generator ----------------
    // >= rather than == so that lowering INTERVAL below the running count
    // wraps at once instead of running through the whole counter range.
    assign w_tick = r_enable && (r_tick_cnt >= r_interval);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!r_enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ---------------- ramp datapath ----------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cur_next[i] = r_cur[i];
            if (w_tick) w_cur_next[i] = ramp_toward(r_cur[i], r_target[i], r_step);
            w_changed[i] = (w_cur_next[i] != r_cur[i]);
            w_busy[i]    = (r_cur[i] != r_target[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_cur[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) r_cur[i] <= w_cur_next[i];
        end
    end

    // ---------------- round-robin channel select ----------------
    // Search starts just after the last served channel; the served channel
    // itself is checked last.
    always_comb begin
        logic [1:0] w_idx;
        w_sel_valid = 1'b0;
        w_sel_ch    = r_rr_ptr;
        w_idx       = r_rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_sel_valid && r_dirty[w_idx]) begin
                w_sel_valid = 1'b1;
                w_sel_ch    = w_idx;
            end
        end
    end

    // ---------------- scheduler FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable && w_sel_valid) begin
                    w_state_next = S_ISSUE;
                    w_launch     = 1'b1;
                end
            end
            S_ISSUE: begin
                // Enable is deliberately ignored here: a started write always completes.
                if (!m_waitrequest) begin
                    w_state_next = S_IDLE;
                    w_accept     = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A channel stays dirty if its value moved after being latched; a tick on
    // the acceptance edge also wins over the clear.
    always_comb begin
        w_dirty_next = r_dirty;
        if (w_accept && (r_cur[r_ch] == r_m_writedata)) w_dirty_next[r_ch] = 1'b0;
        w_dirty_next = w_dirty_next | w_changed;
    end

    always_ff @(posedge clk) begin
        if (reset) r_dirty <= '0;
        else       r_dirty <= w_dirty_next;
    end

    // ---------------- master port registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_write     <= 1'b0;
            r_m_address   <= '0;
            r_m_writedata <= '0;
            r_ch          <= '0;
            r_rr_ptr      <= '0;
        end else if (w_launch) begin
            r_m_write     <= 1'b1;
            r_m_address   <= 4'(PWM_CMP_BASE) + {2'b00, w_sel_ch};
            r_m_writedata <= r_cur[w_sel_ch];
            r_ch          <= w_sel_ch;
        end else if (w_accept) begin
            r_m_write     <= 1'b0;
            r_rr_ptr      <= r_ch;
        end
    end

    assign m_write     = r_m_write;
    assign m_address   = r_m_address;
    assign m_writedata = r_m_writedata;

    // ---------------- slave register writes ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_target[i] <= '0;
            r_step     <= DUTY_W'(1);
            r_interval <= '1;
            r_enable   <= 1'b0;
        end else if (s_write) begin
            case (s_address)
                4'd0, 4'd1, 4'd2, 4'd3: r_target[s_address[1:0]] <= s_writedata[DUTY_W-1:0];
                4'd4:                   r_step                   <= s_writedata[DUTY_W-1:0];
                4'd5:                   r_interval               <= s_writedata[TICK_W-1:0];
                4'd6:                   r_enable                 <= s_writedata[0];
                default: ;
            endcase
        end
    end

    // ---------------- completion interrupt ----------------
`ifdef PWM_FADE_IRQ_EN
    logic r_irq_en;
    logic r_irq_pending;
    logic r_done_prev;
    logic w_done;

    assign w_done = (w_busy == 4'd0) && (r_dirty == 4'd0) && (r_state == S_IDLE);

    // r_done_prev resets high so the idle state right after reset is not
    // mistaken for a ramp finishing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en      <= 1'b0;
            r_irq_pending <= 1'b0;
            r_done_prev   <= 1'b1;
        end else begin
            r_done_prev <= w_done;
            if (s_write && (s_address == 4'd6)) r_irq_en <= s_writedata[1];
            if (w_done && !r_done_prev) begin
                r_irq_pending <= 1'b1;
            end else if (s_write && (s_address == 4'd6) && s_writedata[2]) begin
                r_irq_pending <= 1'b0;
            end
        end
    end

    assign w_irq_pending = r_irq_pending;
    assign w_irq_en      = r_irq_en;
    assign irq           = r_irq_pending & r_irq_en;
`else
    assign w_irq_pending = 1'b0;
    assign w_irq_en      = 1'b0;
    assign irq           = 1'b0;
`endif

    // ---------------- slave readback ----------------
    always_comb begin
        w_rdata = '0;
        case (s_address)
            4'd0, 4'd1, 4'd2, 4'd3: w_rdata = 16'(r_target[s_address[1:0]]);
            4'd4:                   w_rdata = 16'(r_step);
            4'd5:                   w_rdata = 16'(r_interval);
            4'd6:                   w_rdata = {13'd0, 1'b0, w_irq_en, r_enable};
            4'd7:                   w_rdata = {11'd0, w_irq_pending, w_busy};
            4'd8, 4'd9, 4'd10, 4'd11: w_rdata = 16'(r_cur[s_address[1:0]]);
            default:                w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       r_readdata <= '0;
        else if (s_read) r_readdata <= w_rdata;
    end

    assign s_readdata = r_readdata;

endmodule
